// File: rtl/proc_pkg.sv
// Shared state and status encodings for the processor run controller.
package proc_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRun    = 3'd2,
    StRdReq  = 3'd3,
    StRdWait = 3'd4,
    StRdOut  = 3'd5,
    StDone   = 3'd6
  } state_e;

  localparam logic [1:0] StatusIdle = 2'b00;
  localparam logic [1:0] StatusLoad = 2'b10;
  localparam logic [1:0] StatusRun  = 2'b01;
  localparam logic [1:0] StatusDone = 2'b11;

  // Readout states report as running; only the load and terminal states differ.
  function automatic logic [1:0] status_of(state_e s);
    logic [1:0] st;
    st = StatusRun;
    case (s)
      StIdle:  st = StatusIdle;
      StLoad:  st = StatusLoad;
      StDone:  st = StatusDone;
      default: st = StatusRun;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Program-load stream, memory port and result stream of the run controller.
interface proc_run_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (
    input  load_data, load_valid, mem_rdata, res_ready,
    output load_ready, mem_we, mem_re, mem_addr, mem_wdata, res_data, res_valid
  );

  modport slave (
    output load_data, load_valid, mem_rdata, res_ready,
    input  load_ready, mem_we, mem_re, mem_addr, mem_wdata, res_data, res_valid
  );
endinterface

// File: rtl/run_watchdog.sv
// RUN-state watchdog: counts consecutive RUN cycles and flags the last allowed one.
// Only built when RUN_TIMEOUT_EN is defined.
`ifdef RUN_TIMEOUT_EN
module run_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic run_i,
  output logic expired_o
);
  localparam int unsigned LimW = $clog2(TIMEOUT_CYC + 1);

  logic [LimW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run_i ? cnt_q + LimW'(1) : '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == LimW'(TIMEOUT_CYC - 1));
endmodule
`endif

// File: rtl/proc_run_ctrl.sv
// Load / run / readout sequencer for a small processor with a shared memory port.
// Optional RUN watchdog enabled by defining RUN_TIMEOUT_EN.
module proc_run_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RES_BASE    = ADDR_W'(200),
  parameter int unsigned       RES_WORDS   = 4,
  parameter int unsigned       TIMEOUT_CYC = 65535
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   prog_len_i,
  input  logic                end_process_i,
  proc_run_ctrl_if.master     bus,
  output logic [1:0]          status_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o
);
  // Shared between load addressing and result counting (up to 255 results).
  localparam int unsigned CntW = (ADDR_W > 8) ? ADDR_W : 8;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              load_ready_q, load_ready_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        status_q, status_d;
  logic              busy_q, busy_d, done_q, done_d;

`ifdef RUN_TIMEOUT_EN
  logic timeout_q, timeout_d, wd_expired;

  run_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_run_watchdog (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .run_i     (state_q == StRun),
    .expired_o (wd_expired)
  );
  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout_o  = 1'b0;
`endif

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    load_ready_d = load_ready_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    done_d       = done_q;
`ifdef RUN_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          cnt_d  = '0;
          len_d  = prog_len_i;
          done_d = 1'b0;
`ifdef RUN_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (prog_len_i != '0) begin
            state_d      = StLoad;
            load_ready_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StLoad: begin
        if (bus.load_valid && load_ready_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = bus.load_data;
          cnt_d       = cnt_inc;
          if (cnt_inc == CntW'(len_q)) begin
            load_ready_d = 1'b0;
            state_d      = StRun;
          end
        end
      end
      StRun: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (end_process_i) begin
          state_d    = StRdReq;
          cnt_d      = '0;
          mem_re_d   = 1'b1;
          mem_addr_d = RES_BASE;
`ifdef RUN_TIMEOUT_EN
        end else if (wd_expired) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          done_d    = 1'b1;
`endif
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        res_data_d  = bus.mem_rdata;
        res_valid_d = 1'b1;
        state_d     = StRdOut;
      end
      StRdOut: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_inc;
          if (cnt_inc == CntW'(RES_WORDS)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d    = StRdReq;
            mem_re_d   = 1'b1;
            mem_addr_d = RES_BASE + cnt_inc[ADDR_W-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
    status_d = status_of(state_d);
    busy_d   = (state_d != StIdle) && (state_d != StDone);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      len_q        <= '0;
      load_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      status_q     <= StatusIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef RUN_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      load_ready_q <= load_ready_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      status_q     <= status_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef RUN_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_valid  = res_valid_q;
  assign status_o       = status_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory/instruction word width.
REQ-003 SHALL have parameter RES_BASE, default 8'd200, first result-word address read back after a run.
REQ-004 SHALL have parameter RES_WORDS, default 4, number of result words read back (1..255).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535, RUN-state watchdog limit in cycles.
REQ-006 SHALL have port clock  in  1  single system clock; all logic on posedge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  begin load/run/readout sequence.
REQ-009 SHALL have port prog_len  in  ADDR_W  number of program words to load.
REQ-010 SHALL have ports load_data  in  DATA_W, load_valid  in  1, load_ready  out  1: program word stream.
REQ-011 SHALL have ports mem_we  out  1, mem_re  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W: memory port.
REQ-012 SHALL have port status  out  2  processor run status: 00 idle, 10 loading, 01 run, 11 done.
REQ-013 SHALL have port end_process  in  1  processor completion flag, level, from the controller FSM.
REQ-014 SHALL have ports res_data  out  DATA_W, res_valid  out  1, res_ready  in  1: result word stream.
REQ-015 SHALL have ports busy  out  1, done  out  1, timeout  out  1.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, RD_REQ, RD_WAIT, RD_OUT, DONE; all outputs registered.
REQ-017 In IDLE or DONE, start=1 SHALL clear word counter, done and timeout, and go to LOAD (prog_len!=0) or RUN (prog_len==0); start SHALL be ignored in other states.
REQ-018 In LOAD, load_ready=1; each load_valid&&load_ready handshake SHALL produce mem_we=1, mem_addr=counter, mem_wdata=load_data on the next cycle, then counter increments.
REQ-019 After the prog_len-th handshake LOAD SHALL deassert load_ready and enter RUN on the next cycle; no further words accepted.
REQ-020 In RUN, status SHALL hold 01 until end_process=1, then go to RD_REQ with counter cleared.
REQ-021 RD_REQ SHALL pulse mem_re=1 with mem_addr=RES_BASE+counter (mod 2^ADDR_W); RD_WAIT absorbs 1-cycle read latency; RD_OUT SHALL present captured mem_rdata on res_data with res_valid=1.
REQ-022 res_data/res_valid SHALL stay stable until res_ready=1; on handshake counter increments and returns to RD_REQ, or goes to DONE after RES_WORDS words.
REQ-023 In DONE, status=11 and done=1 SHALL hold until next start or reset.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE.
REQ-025 mem_we and mem_re SHALL never be asserted in the same cycle.

Reset
REQ-026 reset=1 SHALL, at the next posedge, from any state including mid-load or mid-readout, force IDLE and drive status=00, load_ready, mem_we, mem_re, res_valid, busy, done, timeout=0, mem_addr, mem_wdata, res_data=0, counters=0.

Configuration
REQ-027 With RUN_TIMEOUT_EN defined, a RUN cycle counter SHALL set timeout=1 (sticky) and jump to DONE without readout when TIMEOUT_CYC cycles elapse without end_process; end_process in the same cycle SHALL win.
REQ-028 Without RUN_TIMEOUT_EN, no watchdog counter SHALL exist, timeout SHALL be tied 0, and RUN waits indefinitely.

Structure
REQ-029 Status encodings (IDLE/LOAD/RUN/DONE codes) and state encoding SHALL live in a shared package proc_pkg also used by the controller.
REQ-030 A sub-module run_watchdog (counter + compare, present only under RUN_TIMEOUT_EN) SHALL hold the timeout logic.

Verification
REQ-031 prog_len=3, words 16'h0003,16'h0021,16'h002A with continuous valid -> mem_we at addr 0,1,2 with those data, then status=01.
REQ-032 load_valid toggled every other cycle, prog_len=2 -> exactly 2 writes, load_ready drops after second handshake.
REQ-033 end_process=1 after 10 RUN cycles, mem[200..203]=1,2,3,4, res_ready=1 -> res_data 1,2,3,4 then done=1, status=11.
REQ-034 res_ready held 0 for 5 cycles on word 0 -> res_data stable, res_valid=1 throughout, no extra mem_re.
REQ-035 reset pulsed mid-LOAD after 1 word -> next cycle status=00, load_ready=0, busy=0; start again reloads from addr 0.
REQ-036 RUN_TIMEOUT_EN, TIMEOUT_CYC=20, end_process never -> timeout=1, done=1 after 20 RUN cycles, no mem_re issued.
